// File: rtl/approx_mac_accum_if.sv
// approx_mac_accum_if: product-in / sum-out valid-ready bundle (master = producer+consumer, slave = accumulator)
interface approx_mac_accum_if #(
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      prod;
  logic             in_clear;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_sat;
  modport master (
    output in_valid, prod, in_clear, out_ready,
    input  in_ready, out_valid, out_sum, out_sat
  );
  modport slave (
    input  in_valid, prod, in_clear, out_ready,
    output in_ready, out_valid, out_sum, out_sat
  );
endinterface

// File: rtl/approx_mac_accum.sv
// approx_mac_accum: sums VEC_LEN biased multiplier products per vector, one result per vector over valid/ready
//   clk, rst_n (async active-low); bus: in_valid/in_ready/prod/in_clear in, out_valid/out_ready/out_sum/out_sat out
//   Optional ACC_SATURATE_EN: saturate at all-ones with a sticky out_sat flag; otherwise wrap and tie out_sat to 0
module approx_mac_accum #(
  parameter int               VEC_LEN = 16,
  parameter int               ACC_W   = 24,
  parameter logic [ACC_W-1:0] BIAS    = ACC_W'(8)
) (
  input logic               clk,
  input logic               rst_n,
  approx_mac_accum_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t           state;
  logic [8:0]       cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic             accept;
  logic             last;
  logic             flush;
  assign bus.in_ready = state != HOLD;
  assign accept       = bus.in_valid & bus.in_ready & ~bus.in_clear;
  assign last         = cnt == 9'(VEC_LEN - 1);
  // clear outranks both accept and the output handshake
  assign flush        = bus.in_clear | (state == HOLD & bus.out_ready);
`ifdef ACC_SATURATE_EN
  logic [ACC_W:0] sum;
  logic           sat;
  logic           sat_nxt;
  assign sum     = {1'b0, acc} + (ACC_W + 1)'(bus.prod) + {1'b0, BIAS};
  assign sat_nxt = sat | sum[ACC_W];
  assign acc_nxt = sat_nxt ? '1 : sum[ACC_W-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sat         <= 1'b0;
      bus.out_sat <= 1'b0;
    end else if (flush) begin
      sat <= 1'b0;
    end else if (accept) begin
      sat <= sat_nxt;
      if (last) bus.out_sat <= sat_nxt;
    end
`else
  assign acc_nxt     = acc + ACC_W'(bus.prod) + BIAS;
  assign bus.out_sat = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
    end else if (flush) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      cnt   <= cnt + 9'd1;
      acc   <= acc_nxt;
      state <= last ? HOLD : ACCUM;
      if (last) begin
        bus.out_valid <= 1'b1;
        bus.out_sum   <= acc_nxt;
      end
    end
endmodule

// File: tb/tb_approx_mac_accum.sv
// tb_approx_mac_accum: directed spec scenarios plus random traffic against a vector-level sum model
module tb_approx_mac_accum;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  approx_mac_accum_if #(.ACC_W(17)) ia ();
  approx_mac_accum_if #(.ACC_W(24)) ib ();
  approx_mac_accum #(.VEC_LEN(4), .ACC_W(17), .BIAS(17'd0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  approx_mac_accum #(.VEC_LEN(2), .ACC_W(24), .BIAS(24'd8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  int     n_run = 0;
  int     n_fail = 0;
  int     vl[2]   = '{4, 2};
  int     accw[2] = '{17, 24};
  longint bias[2] = '{0, 8};
  bit     hold[2];
  int     cnt[2];
  longint tot[2];
  longint esum[2];
  bit     esat[2];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      hold[i] = 0; cnt[i] = 0; tot[i] = 0; esum[i] = 0; esat[i] = 0;
    end
  endfunction
  function automatic void upd(int i, bit v, logic [15:0] p, bit c, bit r);
    longint mx;
    mx = (longint'(1) << accw[i]) - 1;
    if (c || (hold[i] && r)) begin
      hold[i] = 0; cnt[i] = 0; tot[i] = 0;
    end else if (!hold[i] && v) begin
      tot[i] += longint'(p) + bias[i];
      cnt[i]++;
      if (cnt[i] == vl[i]) begin
        hold[i] = 1;
`ifdef ACC_SATURATE_EN
        esum[i] = tot[i] > mx ? mx : tot[i];
        esat[i] = tot[i] > mx;
`else
        esum[i] = tot[i] & mx;
        esat[i] = 0;
`endif
      end
    end
  endfunction
  task automatic chk_all();
    check("a_in_ready", 64'(ia.in_ready), 64'(!hold[0]));
    check("a_out_valid", 64'(ia.out_valid), 64'(hold[0]));
    check("a_out_sum", 64'(ia.out_sum), esum[0]);
    check("a_out_sat", 64'(ia.out_sat), 64'(esat[0]));
    check("b_in_ready", 64'(ib.in_ready), 64'(!hold[1]));
    check("b_out_valid", 64'(ib.out_valid), 64'(hold[1]));
    check("b_out_sum", 64'(ib.out_sum), esum[1]);
    check("b_out_sat", 64'(ib.out_sat), 64'(esat[1]));
  endtask
  task automatic drive(input bit v, input logic [15:0] p, input bit c, input bit r);
    ia.in_valid = v; ia.prod = p; ia.in_clear = c; ia.out_ready = r;
    ib.in_valid = v; ib.prod = p; ib.in_clear = c; ib.out_ready = r;
  endtask
  task automatic cyc(input bit v, input logic [15:0] p, input bit c, input bit r);
    drive(v, p, c, r);
    @(posedge clk);
    upd(0, v, p, c, r);
    upd(1, v, p, c, r);
    @(negedge clk);
    chk_all();
  endtask
  task automatic do_reset();
    drive(0, 16'd0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    drive(0, 16'd0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    chk_all();
    rst_n = 1'b1;
    cyc(0, 16'd0, 0, 0);
    // 1: back-to-back 1..4, consumer always ready
    for (int k = 1; k <= 4; k++) cyc(1, 16'(k), 0, 1);
    check("t1_out_valid", 64'(ia.out_valid), 64'd1);
    check("t1_out_sum", 64'(ia.out_sum), 64'd10);
    check("t1_out_sat", 64'(ia.out_sat), 64'd0);
    cyc(0, 16'd0, 0, 1);
    check("t1_in_ready_back", 64'(ia.in_ready), 64'd1);
    // 2: result held while consumer stalls, new beat refused
    for (int k = 1; k <= 4; k++) cyc(1, 16'(k), 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 16'd7, 0, 0);
      check("t2_in_ready", 64'(ia.in_ready), 64'd0);
      check("t2_out_sum", 64'(ia.out_sum), 64'd10);
    end
    cyc(0, 16'd0, 0, 1);
    // 3: overflow of the 17-bit accumulator
    for (int k = 0; k < 4; k++) cyc(1, 16'hFFFF, 0, 0);
`ifdef ACC_SATURATE_EN
    check("t3_out_sum", 64'(ia.out_sum), 64'h1FFFF);
    check("t3_out_sat", 64'(ia.out_sat), 64'd1);
`else
    check("t3_out_sum", 64'(ia.out_sum), 64'h1FFFC);
    check("t3_out_sat", 64'(ia.out_sat), 64'd0);
`endif
    cyc(0, 16'd0, 0, 1);
    // 4: abort mid-vector, then a clean vector
    cyc(1, 16'd9, 0, 0);
    cyc(1, 16'd9, 0, 0);
    cyc(1, 16'd9, 1, 0);
    check("t4_cleared_valid", 64'(ia.out_valid), 64'd0);
    for (int k = 0; k < 4; k++) cyc(1, 16'd5, 0, 0);
    check("t4_out_sum", 64'(ia.out_sum), 64'd20);
    cyc(0, 16'd0, 0, 0);
    // 5: reset while holding a result
    do_reset();
    check("t5_out_valid", 64'(ia.out_valid), 64'd0);
    check("t5_out_sum", 64'(ia.out_sum), 64'd0);
    check("t5_in_ready", 64'(ia.in_ready), 64'd1);
    for (int k = 0; k < 4; k++) cyc(1, 16'd1, 0, 0);
    check("t5_out_sum_after", 64'(ia.out_sum), 64'd4);
    // 6: bias applied per product on the two-beat instance
    do_reset();
    cyc(1, 16'h0010, 0, 0);
    cyc(1, 16'h0020, 0, 0);
    check("t6_out_valid", 64'(ib.out_valid), 64'd1);
    check("t6_out_sum", 64'(ib.out_sum), 64'h40);
    cyc(0, 16'd0, 0, 1);
    // random traffic, biased towards large products to exercise overflow
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(999) == 0) do_reset();
      cyc($urandom_range(9) < 7,
          ($urandom_range(2) == 0) ? 16'hFFFF - 16'($urandom_range(15)) : 16'($urandom),
          $urandom_range(19) == 0,
          $urandom_range(9) < 6);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
